// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC fetch unit: opcodes, IR field positions,
// fetch FSM state encoding and the NOOP instruction word.
package sisc_pkg;

  // Instruction opcodes (IR[31:28])
  typedef enum logic [3:0] {
    OP_NOOP = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_OR   = 4'h3,
    OP_AND  = 4'h4,
    OP_NOT  = 4'h5,
    OP_XOR  = 4'h6,
    OP_CMP  = 4'h7,
    OP_BXX  = 4'h8,
    OP_JMP  = 4'h9,
    OP_LD   = 4'hA,
    OP_LDI  = 4'hB,
    OP_LDX  = 4'hC,
    OP_ST   = 4'hD,
    OP_STX  = 4'hE,
    OP_HLT  = 4'hF
  } opcode_e;

  // IR field geometry
  localparam int unsigned IR_W    = 32;
  localparam int unsigned FIELD_W = 4;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned OPC_LSB = 28;
  localparam int unsigned MM_LSB  = 24;
  localparam int unsigned RD_LSB  = 20;
  localparam int unsigned RS_LSB  = 16;
  localparam int unsigned RT_LSB  = 12;
  localparam int unsigned IMM_LSB = 0;

  // Word loaded into IR on reset and on a fetch timeout
  localparam logic [IR_W-1:0] NOOP_WORD = '0;

  // Fetch FSM state encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

endpackage

// File: rtl/sisc_fetch_wdog.sv
// REQ-state watchdog for sisc_fetch: counts cycles spent waiting for
// imem_ack and flags expiry on the TIMEOUT-th cycle. Built only when
// SISC_FETCH_TIMEOUT_EN is defined.
module sisc_fetch_wdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  output logic o_expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count while waiting; idle forces zero so each request starts fresh
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_run) begin
      r_cnt <= '0;
    end else if (r_cnt != LAST) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expired_c = i_run && (r_cnt == LAST);

endmodule

// File: rtl/sisc_fetch.sv
// SISC instruction fetch unit: owns PC and IR, fetches over an imem
// req/ack handshake on request from the control FSM, applies branches,
// and exposes the decoded IR fields.
// Optional: define SISC_FETCH_TIMEOUT_EN to add a REQ watchdog
// (sisc_fetch_wdog) that abandons a fetch after TIMEOUT cycles.
module sisc_fetch
  import sisc_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned RST_PC = 0
`ifdef SISC_FETCH_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 255
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_fetch_req,
  input  logic              i_br_load,
  input  logic              i_br_rel,
  output logic              o_fetch_done,
  output logic              o_busy,
  output logic              o_halted,
  output logic              o_fetch_err,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [IR_W-1:0]   i_imem_rdata,
  output logic [ADDR_W-1:0] o_pc,
  output logic [3:0]        o_opcode,
  output logic [3:0]        o_mm,
  output logic [3:0]        o_rd,
  output logic [3:0]        o_rs,
  output logic [3:0]        o_rt,
  output logic [15:0]       o_imm
);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [IR_W-1:0]   r_ir;
  logic              r_pending;
  logic              r_fetch_done;
  logic              r_halted;
  logic              r_fetch_err;

  logic [0:0]        w_state_nxt;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [IR_W-1:0]   w_ir_nxt;
  logic              w_pending_nxt;
  logic              w_fetch_done_nxt;
  logic              w_halted_nxt;
  logic              w_fetch_err_nxt;

  logic signed [IMM_W-1:0] w_imm_s;
  logic [ADDR_W-1:0]       w_imm_rel;
  logic [ADDR_W-1:0]       w_imm_abs;
  logic                    w_wd_expired;

  // Branch offsets come from the IR currently held
  assign w_imm_s   = $signed(r_ir[IMM_LSB +: IMM_W]);
  assign w_imm_rel = ADDR_W'(w_imm_s);
  assign w_imm_abs = ADDR_W'(r_ir[IMM_LSB +: IMM_W]);

`ifdef SISC_FETCH_TIMEOUT_EN
  sisc_fetch_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk         (clk),
    .rst         (rst),
    .i_run       (r_state == ST_REQ),
    .o_expired_c (w_wd_expired)
  );
`else
  assign w_wd_expired = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_pc         <= ADDR_W'(RST_PC);
      r_ir         <= NOOP_WORD;
      r_pending    <= 1'b0;
      r_fetch_done <= 1'b0;
      r_halted     <= 1'b0;
      r_fetch_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_ir         <= w_ir_nxt;
      r_pending    <= w_pending_nxt;
      r_fetch_done <= w_fetch_done_nxt;
      r_halted     <= w_halted_nxt;
      r_fetch_err  <= w_fetch_err_nxt;
    end
  end

  // Next-state: branch/fetch arbitration in IDLE, handshake in REQ
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_ir_nxt         = r_ir;
    w_pending_nxt    = r_pending;
    w_fetch_done_nxt = 1'b0;
    w_halted_nxt     = r_halted;
    w_fetch_err_nxt  = r_fetch_err;

    unique case (r_state)
      ST_IDLE: begin
        if (i_br_load) begin
          // Branch wins the cycle; a simultaneous fetch is deferred one cycle
          w_pc_nxt      = i_br_rel ? (r_pc + w_imm_rel) : w_imm_abs;
          w_pending_nxt = r_pending | (i_fetch_req & ~r_halted);
        end else if ((i_fetch_req | r_pending) & ~r_halted) begin
          w_state_nxt   = ST_REQ;
          w_pending_nxt = 1'b0;
        end
      end
      ST_REQ: begin
        if (i_br_load) begin
          w_fetch_err_nxt = 1'b1;
        end
        if (i_imem_ack) begin
          w_ir_nxt         = i_imem_rdata;
          w_pc_nxt         = r_pc + ADDR_W'(1);
          w_fetch_done_nxt = 1'b1;
          w_halted_nxt     = r_halted | (i_imem_rdata[OPC_LSB +: FIELD_W] == OP_HLT);
          w_state_nxt      = ST_IDLE;
        end else if (w_wd_expired) begin
          w_ir_nxt         = NOOP_WORD;
          w_fetch_err_nxt  = 1'b1;
          w_fetch_done_nxt = 1'b1;
          w_state_nxt      = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_fetch_done = r_fetch_done;
  assign o_busy       = (r_state == ST_REQ);
  assign o_imem_req   = (r_state == ST_REQ);
  assign o_imem_addr  = r_pc;
  assign o_halted     = r_halted;
  assign o_fetch_err  = r_fetch_err;
  assign o_pc         = r_pc;
  assign o_opcode     = r_ir[OPC_LSB +: FIELD_W];
  assign o_mm         = r_ir[MM_LSB  +: FIELD_W];
  assign o_rd         = r_ir[RD_LSB  +: FIELD_W];
  assign o_rs         = r_ir[RS_LSB  +: FIELD_W];
  assign o_rt         = r_ir[RT_LSB  +: FIELD_W];
  assign o_imm        = r_ir[IMM_LSB +: IMM_W];

endmodule

// File: tb/tb_sisc_fetch.sv
// Self-checking bench for sisc_fetch. Expected IR/PC per fetch are queued
// when the fetch is issued and compared when fetch_done pulses.
// Timeout scenario runs only when SISC_FETCH_TIMEOUT_EN is defined.
module tb_sisc_fetch;

  logic        clk;
  logic        rst;
  logic        i_fetch_req;
  logic        i_br_load;
  logic        i_br_rel;
  logic        o_fetch_done;
  logic        o_busy;
  logic        o_halted;
  logic        o_fetch_err;
  logic        o_imem_req;
  logic [15:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic [15:0] o_pc;
  logic [3:0]  o_opcode;
  logic [3:0]  o_mm;
  logic [3:0]  o_rd;
  logic [3:0]  o_rs;
  logic [3:0]  o_rt;
  logic [15:0] o_imm;

  typedef struct packed {
    logic [31:0] word;
    logic [15:0] pc;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] m_pc;
  logic        m_halted;

  sisc_fetch #(
    .ADDR_W (16),
    .RST_PC (0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_fetch_req  (i_fetch_req),
    .i_br_load    (i_br_load),
    .i_br_rel     (i_br_rel),
    .o_fetch_done (o_fetch_done),
    .o_busy       (o_busy),
    .o_halted     (o_halted),
    .o_fetch_err  (o_fetch_err),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_ack   (i_imem_ack),
    .i_imem_rdata (i_imem_rdata),
    .o_pc         (o_pc),
    .o_opcode     (o_opcode),
    .o_mm         (o_mm),
    .o_rd         (o_rd),
    .o_rs         (o_rs),
    .o_rt         (o_rt),
    .o_imm        (o_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute guard against a hung run
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_fetch_req  = 1'b0;
    i_br_load    = 1'b0;
    i_br_rel     = 1'b0;
    i_imem_ack   = 1'b0;
    i_imem_rdata = 32'h0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_pc = 16'h0000;
    m_halted = 1'b0;
    sb_q.delete();
  endtask

  // Issue one fetch, ack after `delay` REQ cycles, check the result
  task automatic do_fetch(input logic [31:0] word, input int delay, output int lat);
    exp_t e;
    int   n;
    sb_q.push_back('{word: word, pc: m_pc + 16'd1});
    i_fetch_req = 1'b1;
    tick();
    i_fetch_req = 1'b0;
    n = 0;
    while (o_imem_req !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    checks++;
    if (o_imem_req !== 1'b1) begin
      errors++;
      $display("FAIL fetch_req_wait: imem_req=%b required 1", o_imem_req);
    end
    checks++;
    if (o_imem_addr !== m_pc) begin
      errors++;
      $display("FAIL imem_addr: got %h required %h", o_imem_addr, m_pc);
    end
    repeat (delay) tick();
    checks++;
    if ({o_imem_req, o_busy, o_imem_addr} !== {1'b1, 1'b1, m_pc}) begin
      errors++;
      $display("FAIL req_hold: req=%b busy=%b addr=%h required 1 1 %h",
               o_imem_req, o_busy, o_imem_addr, m_pc);
    end
    i_imem_ack   = 1'b1;
    i_imem_rdata = word;
    tick();
    i_imem_ack   = 1'b0;
    i_imem_rdata = $urandom;
    lat = n + delay + 2;
    checks++;
    if (o_fetch_done !== 1'b1) begin
      errors++;
      $display("FAIL fetch_done: got %b required 1", o_fetch_done);
    end
    m_pc = m_pc + 16'd1;
    m_halted = m_halted | (word[31:28] == 4'hF);
    if (o_fetch_done === 1'b1 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if ({o_opcode, o_mm, o_rd, o_rs, o_imm} !== e.word || o_rt !== e.word[15:12]) begin
        errors++;
        $display("FAIL ir_fields: got %h%h%h%h_%h rt=%h required %h",
                 o_opcode, o_mm, o_rd, o_rs, o_imm, o_rt, e.word);
      end
      checks++;
      if (o_pc !== e.pc) begin
        errors++;
        $display("FAIL pc_after_fetch: got %h required %h", o_pc, e.pc);
      end
    end
    checks++;
    if ({o_halted, o_busy} !== {m_halted, 1'b0}) begin
      errors++;
      $display("FAIL halted_busy: halted=%b busy=%b required %b 0", o_halted, o_busy, m_halted);
    end
  endtask

  task automatic do_branch(input logic rel, input logic [15:0] exp_pc);
    i_br_load = 1'b1;
    i_br_rel  = rel;
    tick();
    i_br_load = 1'b0;
    i_br_rel  = 1'b0;
    checks++;
    if (o_pc !== exp_pc) begin
      errors++;
      $display("FAIL branch rel=%b: pc=%h required %h", rel, o_pc, exp_pc);
    end
    m_pc = exp_pc;
  endtask

  task automatic test_reset();
    i_fetch_req = 1'b1;
    i_br_load   = 1'b1;
    do_reset();
    checks++;
    if ({o_fetch_done, o_busy, o_halted, o_fetch_err, o_imem_req} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: done/busy/halt/err/req=%b%b%b%b%b required 00000",
               o_fetch_done, o_busy, o_halted, o_fetch_err, o_imem_req);
    end
    checks++;
    if (o_pc !== 16'h0000 || {o_opcode, o_mm, o_rd, o_rs, o_imm} !== 32'h0) begin
      errors++;
      $display("FAIL reset_pc_ir: pc=%h op=%h imm=%h required 0000 0 0000", o_pc, o_opcode, o_imm);
    end
  endtask

  task automatic test_basic_fetch();
    int lat;
    do_reset();
    do_fetch(32'h1823_4000, 0, lat);
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL basic_latency: got %0d required 2", lat);
    end
    checks++;
    if ({o_opcode, o_mm, o_pc} !== {4'h1, 4'h8, 16'h0001}) begin
      errors++;
      $display("FAIL basic_fields: op=%h mm=%h pc=%h required 1 8 0001", o_opcode, o_mm, o_pc);
    end
    tick();
    checks++;
    if (o_fetch_done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: fetch_done=%b required 0", o_fetch_done);
    end
  endtask

  task automatic test_branch();
    int lat;
    do_reset();
    do_fetch(32'h8000_000F, 0, lat);
    do_branch(1'b0, 16'h000F);
    do_fetch(32'h8000_FFFC, 1, lat);
    do_branch(1'b1, 16'h000C);
    do_fetch(32'h8000_0040, 0, lat);
    do_branch(1'b0, 16'h0040);
    checks++;
    if (o_fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL branch_err: fetch_err=%b required 0", o_fetch_err);
    end
  endtask

  task automatic test_wrap();
    int lat;
    do_reset();
    do_fetch(32'h8000_FFFF, 0, lat);
    do_branch(1'b0, 16'hFFFF);
    do_fetch(32'h9000_FFFE, 2, lat);
    checks++;
    if (o_pc !== 16'h0000 || o_fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL pc_wrap: pc=%h err=%b required 0000 0", o_pc, o_fetch_err);
    end
    do_branch(1'b1, 16'hFFFE);
  endtask

  task automatic test_pending();
    int lat;
    do_reset();
    do_fetch(32'h8000_0020, 0, lat);
    i_fetch_req = 1'b1;
    i_br_load   = 1'b1;
    i_br_rel    = 1'b0;
    tick();
    i_fetch_req = 1'b0;
    i_br_load   = 1'b0;
    checks++;
    if (o_pc !== 16'h0020 || o_imem_req !== 1'b0) begin
      errors++;
      $display("FAIL pend_branch: pc=%h req=%b required 0020 0", o_pc, o_imem_req);
    end
    tick();
    checks++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== 16'h0020) begin
      errors++;
      $display("FAIL pend_issue: req=%b addr=%h required 1 0020", o_imem_req, o_imem_addr);
    end
    i_br_load   = 1'b1;
    i_fetch_req = 1'b1;
    tick();
    i_br_load   = 1'b0;
    i_fetch_req = 1'b0;
    checks++;
    if ({o_fetch_err, o_imem_req} !== 2'b11 || o_pc !== 16'h0020) begin
      errors++;
      $display("FAIL busy_branch: err=%b req=%b pc=%h required 1 1 0020", o_fetch_err, o_imem_req, o_pc);
    end
    i_imem_ack   = 1'b1;
    i_imem_rdata = 32'h3000_0000;
    tick();
    i_imem_ack   = 1'b0;
    checks++;
    if (o_fetch_done !== 1'b1 || o_pc !== 16'h0021 || o_opcode !== 4'h3) begin
      errors++;
      $display("FAIL pend_done: done=%b pc=%h op=%h required 1 0021 3", o_fetch_done, o_pc, o_opcode);
    end
    tick();
    checks++;
    if (o_imem_req !== 1'b0 || o_fetch_err !== 1'b1) begin
      errors++;
      $display("FAIL busy_fetch_ignored: req=%b err=%b required 0 1", o_imem_req, o_fetch_err);
    end
  endtask

  task automatic test_back_to_back();
    int          lat;
    logic [31:0] w;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      w = {4'($urandom_range(0, 14)), 28'($urandom)};
      do_fetch(w, i % 4, lat);
    end
    checks++;
    if (o_pc !== 16'h0008) begin
      errors++;
      $display("FAIL b2b_pc: pc=%h required 0008", o_pc);
    end
  endtask

  task automatic test_halt();
    int lat;
    int seen;
    do_reset();
    do_fetch(32'h2000_0001, 0, lat);
    do_fetch(32'hF000_0000, 1, lat);
    i_fetch_req = 1'b1;
    tick();
    i_fetch_req = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (o_imem_req !== 1'b0 || o_busy !== 1'b0) seen++;
      tick();
    end
    checks++;
    if (seen != 0 || o_halted !== 1'b1 || o_pc !== 16'h0002) begin
      errors++;
      $display("FAIL halt_block: req_cycles=%0d halted=%b pc=%h required 0 1 0002", seen, o_halted, o_pc);
    end
  endtask

  task automatic test_rst_mid_req();
    int lat;
    do_reset();
    do_fetch(32'h5123_0000, 0, lat);
    do_fetch(32'h6000_0000, 0, lat);
    i_fetch_req = 1'b1;
    tick();
    i_fetch_req = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (o_imem_req !== 1'b0 || o_pc !== 16'h0000) begin
      errors++;
      $display("FAIL async_rst: req=%b pc=%h required 0 0000", o_imem_req, o_pc);
    end
    tick();
    rst = 1'b0;
    i_imem_ack   = 1'b1;
    i_imem_rdata = 32'h5555_5555;
    tick();
    i_imem_ack   = 1'b0;
    checks++;
    if ({o_fetch_done, o_imem_req} !== 2'b00 || o_opcode !== 4'h0 || o_pc !== 16'h0000) begin
      errors++;
      $display("FAIL late_ack: done=%b req=%b op=%h pc=%h required 0 0 0 0000",
               o_fetch_done, o_imem_req, o_opcode, o_pc);
    end
  endtask

`ifdef SISC_FETCH_TIMEOUT_EN
  task automatic test_timeout();
    int lat;
    int n;
    do_reset();
    do_fetch(32'h5000_1234, 0, lat);
    i_fetch_req = 1'b1;
    tick();
    i_fetch_req = 1'b0;
    n = 0;
    while (o_fetch_done !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n != 255) begin
      errors++;
      $display("FAIL timeout_cycles: got %0d required 255", n);
    end
    checks++;
    if ({o_fetch_err, o_imem_req} !== 2'b10 || o_opcode !== 4'h0 || o_pc !== 16'h0001) begin
      errors++;
      $display("FAIL timeout_state: err=%b req=%b op=%h pc=%h required 1 0 0 0001",
               o_fetch_err, o_imem_req, o_opcode, o_pc);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    test_reset();
    test_basic_fetch();
    test_branch();
    test_wrap();
    test_pending();
    test_back_to_back();
    test_halt();
    test_rst_mid_req();
`ifdef SISC_FETCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
